// File: rtl/square_sequencer_if.sv
// -----------------------------------------------------------------------------
// square_sequencer_if
// Groups the video-timing inputs, the mode/step controls and the colour and
// status outputs of square_sequencer into one bundle.
//
// Signals:
//   i_pix_stb    pixel strobe, one clock wide
//   i_frame_end  one-cycle pulse at the end of the last visible line
//   i_x / i_y    current pixel column / row
//   i_mode       0 = auto advance, 1 = manual advance
//   i_step       manual advance request (level)
//   o_sel        index of the current square
//   o_lit        high while a square is shown
//   o_r/o_g/o_b  registered pixel colour
//
// Modports:
//   master  drives the inputs and observes the outputs (timing generator side)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface square_sequencer_if;
    logic       i_pix_stb;
    logic       i_frame_end;
    logic [9:0] i_x;
    logic [8:0] i_y;
    logic       i_mode;
    logic       i_step;
    logic [1:0] o_sel;
    logic       o_lit;
    logic [3:0] o_r;
    logic [3:0] o_g;
    logic [3:0] o_b;

    modport master (
        output i_pix_stb, i_frame_end, i_x, i_y, i_mode, i_step,
        input  o_sel, o_lit, o_r, o_g, o_b
    );

    modport slave (
        input  i_pix_stb, i_frame_end, i_x, i_y, i_mode, i_step,
        output o_sel, o_lit, o_r, o_g, o_b
    );
endinterface

// File: rtl/square_sequencer.sv
// -----------------------------------------------------------------------------
// square_sequencer
// Lights one of four fixed squares on a 640x480 display at a time. In auto
// mode the lit square stays up for HOLD_FRAMES frames, then the screen shows
// only the grey layout for GAP_FRAMES frames before the next square lights.
// In manual mode each rising edge of i_step advances to the next square.
//
// Parameters:
//   HOLD_FRAMES  frames a square stays lit in auto mode (1-255)
//   GAP_FRAMES   blank frames between squares in auto mode (0-255, 0 = none)
//
// Ports:
//   i_clk   100 MHz system clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     square_sequencer_if.slave (timing inputs, controls, colour out)
// -----------------------------------------------------------------------------
module square_sequencer #(
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned GAP_FRAMES  = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    square_sequencer_if.slave  bus
);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] GAP_LAST  = (GAP_FRAMES == 0) ? 8'd0 : 8'(GAP_FRAMES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        step_q;
    logic        mode_q;
    logic        step_rise;
    logic        mode_change;
    logic [3:0]  in_sq;
    logic [11:0] rgb_q, rgb_d;

    assign step_rise   = bus.i_step & ~step_q;
    assign mode_change = bus.i_mode ^ mode_q;

    // Sequencer registers. mode_q captures the live mode during reset so that
    // coming out of reset is never mistaken for a mode change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SHOW;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            step_q  <= 1'b0;
            mode_q  <= bus.i_mode;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            step_q  <= bus.i_step;
            mode_q  <= bus.i_mode;
        end
    end

    // Next-state logic. A mode change outranks everything, including a step
    // edge in the same cycle. The index only moves on a frame_end or a step
    // edge, so a square never switches in the middle of a frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (mode_change) begin
            state_d = SHOW;
            cnt_d   = 8'd0;
        end else if (bus.i_mode) begin
            cnt_d = 8'd0;
            if (step_rise) begin
                idx_d   = idx_q + 2'd1;
                state_d = SHOW;
            end
        end else if (bus.i_frame_end) begin
            unique case (state_q)
                SHOW: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = 8'd0;
                        if (GAP_FRAMES == 0) begin
                            idx_d = idx_q + 2'd1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = 8'd0;
                        idx_d   = idx_q + 2'd1;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = SHOW;
                end
            endcase
        end
    end

    // Square hit tests use strict bounds so the squares are separated by
    // background gutters. Anything beyond the visible area falls outside all
    // four squares.
    always_comb begin
        in_sq    = 4'b0000;
        in_sq[0] = (bus.i_x > 10'd0)   && (bus.i_x < 10'd150) &&
                   (bus.i_y > 9'd0)    && (bus.i_y < 9'd110);
        in_sq[1] = (bus.i_x > 10'd155) && (bus.i_x < 10'd305) &&
                   (bus.i_y > 9'd115)  && (bus.i_y < 9'd225);
        in_sq[2] = (bus.i_x > 10'd310) && (bus.i_x < 10'd460) &&
                   (bus.i_y > 9'd230)  && (bus.i_y < 9'd335);
        in_sq[3] = (bus.i_x > 10'd465) && (bus.i_x < 10'd615) &&
                   (bus.i_y > 9'd340)  && (bus.i_y < 9'd450);
    end

    // The lit square is red; every other square (including the selected one
    // during a gap) is drawn dim grey so the layout stays visible.
    always_comb begin
        rgb_d = 12'h000;
        if ((state_q == SHOW) && in_sq[idx_q]) begin
            rgb_d = 12'hF00;
        end else if (|in_sq) begin
            rgb_d = 12'h333;
        end
    end

    // Colour register advances only on pixel strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= 12'h000;
        end else if (bus.i_pix_stb) begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.o_sel = idx_q;
    assign bus.o_lit = (state_q == SHOW);
    assign bus.o_r   = rgb_q[11:8];
    assign bus.o_g   = rgb_q[7:4];
    assign bus.o_b   = rgb_q[3:0];

endmodule

// File: doc/square_sequencer.md
SQUARE_SEQUENCER -- requirements
Module: square_sequencer

Interface
REQ-001 Parameter HOLD_FRAMES, default 60, the number of frames a square stays lit in auto mode; legal range 1-255.
REQ-002 Parameter GAP_FRAMES, default 15, the number of blank frames between squares in auto mode; legal range 0-255, where 0 means no gap.
REQ-003 i_clk  in  1  100 MHz system clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset; synchronous, active-high.
REQ-005 i_pix_stb  in  1  25 MHz pixel strobe; one i_clk cycle wide.
REQ-006 i_frame_end  in  1  one-cycle pulse at end of the last visible line, from the timing generator.
REQ-007 i_x  in  10  current pixel column, 0-639 visible.
REQ-008 i_y  in  9  current pixel row, 0-479 visible.
REQ-009 i_mode  in  1  0 = auto advance, 1 = manual advance; already synchronised.
REQ-010 i_step  in  1  manual advance request, level, already debounced and synchronised.
REQ-011 o_sel  out  2  index of the currently lit square, 0-3.
REQ-012 o_lit  out  1  1 when a square is lit (state SHOW).
REQ-013 o_r, o_g, o_b  out  4 each  registered pixel colour.

Function
REQ-014 The FSM SHALL have exactly two states, SHOW and GAP, plus a 2-bit index and an 8-bit frame counter.
REQ-015 Square geometry (strict inequalities) SHALL be:
- sq0: 0<x<150, 0<y<110
- sq1: 155<x<305, 115<y<225
- sq2: 310<x<460, 230<y<335
- sq3: 465<x<615, 340<y<450
REQ-016 In auto mode, the frame counter SHALL increment on each i_frame_end pulse.
REQ-017 In SHOW, when the counter reaches HOLD_FRAMES-1 and i_frame_end is high, the FSM SHALL clear the counter and go to GAP, or go directly to SHOW with index+1 if GAP_FRAMES=0.
REQ-018 In GAP, when the counter reaches GAP_FRAMES-1 and i_frame_end is high, the FSM SHALL clear the counter, increment the index, and enter SHOW.
REQ-019 Index increment SHALL wrap 3 -> 0.
REQ-020 In manual mode, the frame counter SHALL hold at 0 and i_frame_end SHALL be ignored.
REQ-021 In manual mode, a rising edge of i_step (registered previous value) SHALL advance the index by one with wrap and force state SHOW; a held i_step SHALL produce exactly one advance.
REQ-022 A manual step arriving in GAP SHALL advance the index and enter SHOW in the same cycle.
REQ-023 Any change of i_mode SHALL clear the frame counter and force state SHOW while keeping the index.
REQ-024 If a mode change and an i_step edge occur in the same cycle, the mode-change rule SHALL apply and no advance SHALL occur.
REQ-025 o_sel and o_lit SHALL reflect the state register directly, with no added latency.
REQ-026 The colour register SHALL update only on cycles with i_pix_stb=1, giving 1 pixel-strobe latency from i_x/i_y to colour.
REQ-027 Pixel colour rules:
- pixel inside square o_sel and o_lit=1: R=4'hF, G=0, B=0;
- pixel inside any other square: R=G=B=4'h3 (dim grey outline of layout);
- otherwise, including x>=640 or y>=480: 0.
REQ-028 The index SHALL change only in the cycle of i_frame_end or of an i_step edge, so no mid-frame tearing occurs in auto mode.

Reset
REQ-029 On i_rst=1 at a clock edge, the block SHALL set state=SHOW, index=0, counter=0, step-edge register=0, and o_r/o_g/o_b=0.
REQ-030 Reset SHALL take priority over all other inputs, including i_pix_stb, i_frame_end and i_step.
REQ-031 Reset asserted mid-SHOW or mid-GAP SHALL return the block to SHOW with index 0 on the next edge.
REQ-032 After reset, o_sel=0 and o_lit=1.

Verification
REQ-033 Auto cycle: HOLD=2, GAP=1, mode=0, 12 frame_end pulses -> o_sel sequence 0,0,gap,1,1,gap,2,2,gap,3,3,gap, then 0.
REQ-034 GAP=0: HOLD=1, 5 frame_end pulses -> o_lit stays 1 and o_sel goes 0,1,2,3,0.
REQ-035 Manual: mode=1, i_step held high 10 cycles, twice, plus frame_end pulses in between -> o_sel advances 0->1->2 only.
REQ-036 Pixel: index=1 lit, stimulus x=200,y=150 on pix_stb -> next pix_stb cycle RGB=F,0,0; stimulus x=20,y=20 -> 3,3,3; stimulus x=152,y=112 -> 0,0,0.
REQ-037 Reset mid-GAP: i_rst pulse while in GAP with index 2 -> next cycle o_sel=0, o_lit=1, RGB=0.
REQ-038 Mode change during SHOW at counter=1 -> counter=0 and no index change; a simultaneous i_step edge causes no advance.
